// File: rtl/counter_seq_pkg.sv
// Shared definitions for the counter sequencer: FSM state encoding and prescaler sizing helper.
package counter_seq_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } seq_state_t;

   // Width of a counter that must hold 0..max_val; never narrower than one bit.
   function automatic int presc_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/counter_sequencer_if.sv
// Control/status bundle between a controller (master) and the counter sequencer (slave).
interface counter_sequencer_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic             abort;
   logic             pause;
   logic             up;
   logic             auto_reload;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] term_val;
   logic [WIDTH-1:0] count;
   logic             busy;
   logic             done;
   logic             wrap;

   modport master (
      output start, abort, pause, up, auto_reload, load_val, term_val,
      input  count, busy, done, wrap
   );

   modport slave (
      input  start, abort, pause, up, auto_reload, load_val, term_val,
      output count, busy, done, wrap
   );
endinterface

// File: rtl/sync_counter_core.sv
// WIDTH-bit synchronous up/down counter with load priority and a registered roll-over flag.
module sync_counter_core #(
   parameter int WIDTH = 4
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   input  logic             i_en,
   input  logic             i_up,
   output logic [WIDTH-1:0] o_q,
   output logic             o_wrap
);
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] r_q;
   logic             r_wrap;

   // Counter register: load beats step; wrap flags only a stepping roll-over.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_q    <= '0;
         r_wrap <= 1'b0;
      end else if (i_load) begin
         r_q    <= i_load_val;
         r_wrap <= 1'b0;
      end else if (i_en) begin
         if (i_up) begin
            r_q    <= r_q + ONE;
            r_wrap <= &r_q;
         end else begin
            r_q    <= r_q - ONE;
            r_wrap <= ~|r_q;
         end
      end else begin
         r_q    <= r_q;
         r_wrap <= 1'b0;
      end
   end

   assign o_q    = r_q;
   assign o_wrap = r_wrap;
endmodule

// File: rtl/counter_sequencer.sv
// Sequencer owning load/enable of sync_counter_core: IDLE/RUN/PAUSE/DONE with abort and auto-reload.
// Optional prescaler built when COUNTER_SEQ_PRESCALER_EN is defined (adds parameter PRESCALE).
module counter_sequencer
   import counter_seq_pkg::*;
#(
   parameter int WIDTH = 4
`ifdef COUNTER_SEQ_PRESCALER_EN
   , parameter int PRESCALE = 0
`endif
) (
   input  logic              i_clk,
   input  logic              i_reset,
   counter_sequencer_if.slave bus
);
   seq_state_t       r_state;
   seq_state_t       w_state_nxt;
   logic [WIDTH-1:0] r_load_q;
   logic [WIDTH-1:0] r_term_q;
   logic             r_up_q;
   logic             r_reload_q;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] w_q;
   logic [WIDTH-1:0] w_core_val;
   logic             w_core_load;
   logic             w_core_en;
   logic             w_latch;
   logic             w_done_nxt;
   logic             w_wrap;
   logic             w_tick;

`ifdef COUNTER_SEQ_PRESCALER_EN
   localparam int             PS_W   = presc_width(PRESCALE);
   localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE);

   logic [PS_W-1:0] r_presc;
   logic            w_presc_run;

   assign w_tick      = (r_presc == PS_MAX);
   assign w_presc_run = (r_state == ST_RUN) && !bus.abort && !bus.pause;

   // Prescaler phase: restarts on start, frozen whenever the run is not stepping.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_presc <= '0;
      end else if (w_latch) begin
         r_presc <= '0;
      end else if (w_presc_run) begin
         r_presc <= w_tick ? '0 : r_presc + PS_W'(1);
      end else begin
         r_presc <= r_presc;
      end
   end
`else
   assign w_tick = 1'b1;
`endif

   // Next-state and core control decode; abort > pause > terminal > step.
   always_comb begin
      w_state_nxt = r_state;
      w_core_load = 1'b0;
      w_core_val  = r_load_q;
      w_core_en   = 1'b0;
      w_latch     = 1'b0;
      w_done_nxt  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.start) begin
               w_latch     = 1'b1;
               w_core_load = 1'b1;
               w_core_val  = bus.load_val;
               w_state_nxt = ST_RUN;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (bus.abort) begin
               w_state_nxt = ST_IDLE;
            end else if (bus.pause) begin
               w_state_nxt = ST_PAUSE;
            end else if (w_tick) begin
               if (w_q == r_term_q) begin
                  w_done_nxt = 1'b1;
                  if (r_reload_q) begin
                     w_core_load = 1'b1;
                  end else begin
                     w_state_nxt = ST_DONE;
                  end
               end else begin
                  w_core_en = 1'b1;
               end
            end else begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_PAUSE: begin
            if (bus.abort) begin
               w_state_nxt = ST_IDLE;
            end else if (!bus.pause) begin
               w_state_nxt = ST_RUN;
            end else begin
               w_state_nxt = ST_PAUSE;
            end
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State register and registered status flags.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_state <= ST_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_PAUSE);
         r_done  <= w_done_nxt;
      end
   end

   // Run parameters captured at start.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_load_q   <= '0;
         r_term_q   <= '0;
         r_up_q     <= 1'b0;
         r_reload_q <= 1'b0;
      end else if (w_latch) begin
         r_load_q   <= bus.load_val;
         r_term_q   <= bus.term_val;
         r_up_q     <= bus.up;
         r_reload_q <= bus.auto_reload;
      end else begin
         r_load_q   <= r_load_q;
         r_term_q   <= r_term_q;
         r_up_q     <= r_up_q;
         r_reload_q <= r_reload_q;
      end
   end

   sync_counter_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_load     (w_core_load),
      .i_load_val (w_core_val),
      .i_en       (w_core_en),
      .i_up       (r_up_q),
      .o_q        (w_q),
      .o_wrap     (w_wrap)
   );

   assign bus.count = w_q;
   assign bus.busy  = r_busy;
   assign bus.done  = r_done;
   assign bus.wrap  = w_wrap;
endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: vector table, hand-written corner sequences, randomized run vs reference model.
module tb_counter_sequencer;
   localparam int W    = 4;
   localparam int MAXV = (1 << W) - 1;
`ifdef COUNTER_SEQ_PRESCALER_EN
   localparam int P = 3;
`else
   localparam int P = 0;
`endif
   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;
   localparam int M_DONE  = 3;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   total = 0;
   int   bad = 0;

   int m_mode, m_count, m_busy, m_done, m_wrap, m_lq, m_tq, m_uq, m_rq, m_pc;

   always #5 clk = ~clk;

   counter_sequencer_if #(.WIDTH(W)) bus ();

   counter_sequencer #(
      .WIDTH (W)
`ifdef COUNTER_SEQ_PRESCALER_EN
      , .PRESCALE (P)
`endif
   ) dut (
      .i_clk   (clk),
      .i_reset (reset),
      .bus     (bus.slave)
   );

   typedef struct {
      logic st, ab, pa, up, rl;
      int   ld, tm;
      int   c, b, d, w;
   } vec_t;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input logic st, input logic ab, input logic pa, input logic up,
                        input logic rl, input int ld, input int tm);
      bus.start       = st;
      bus.abort       = ab;
      bus.pause       = pa;
      bus.up          = up;
      bus.auto_reload = rl;
      bus.load_val    = W'(ld);
      bus.term_val    = W'(tm);
   endtask

   // Reference behaviour for one clock edge, from the inputs present at that edge.
   task automatic model_edge();
      int  nc;
      bit  tick;
      m_done = 0;
      m_wrap = 0;
      if (!reset) begin
         m_mode = M_IDLE; m_count = 0; m_lq = 0; m_tq = 0; m_uq = 0; m_rq = 0; m_pc = 0;
      end else begin
         case (m_mode)
            M_IDLE: if (bus.start) begin
               m_count = int'(bus.load_val);
               m_lq = int'(bus.load_val); m_tq = int'(bus.term_val);
               m_uq = int'(bus.up); m_rq = int'(bus.auto_reload);
               m_pc = 0; m_mode = M_RUN;
            end
            M_RUN: if (bus.abort) m_mode = M_IDLE;
               else if (bus.pause) m_mode = M_PAUSE;
               else begin
                  tick = (m_pc == P);
                  m_pc = tick ? 0 : m_pc + 1;
                  if (tick) begin
                     if (m_count == m_tq) begin
                        m_done = 1;
                        if (m_rq != 0) m_count = m_lq;
                        else m_mode = M_DONE;
                     end else begin
                        nc = (m_uq != 0) ? m_count + 1 : m_count - 1;
                        m_wrap = (nc < 0 || nc > MAXV) ? 1 : 0;
                        m_count = (nc + MAXV + 1) % (MAXV + 1);
                     end
                  end
               end
            M_PAUSE: if (bus.abort) m_mode = M_IDLE;
               else if (!bus.pause) m_mode = M_RUN;
            default: m_mode = M_IDLE;
         endcase
      end
      m_busy = (m_mode == M_RUN || m_mode == M_PAUSE) ? 1 : 0;
   endtask

   task automatic edge_only();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic step_check(input string tag);
      edge_only();
      chk({tag, ".count"}, int'(bus.count), m_count);
      chk({tag, ".busy"},  int'(bus.busy),  m_busy);
      chk({tag, ".done"},  int'(bus.done),  m_done);
      chk({tag, ".wrap"},  int'(bus.wrap),  m_wrap);
   endtask

   task automatic expect_now(input string tag, input int c, input int b, input int d, input int w);
      chk({tag, ".count"}, int'(bus.count), c);
      chk({tag, ".busy"},  int'(bus.busy),  b);
      chk({tag, ".done"},  int'(bus.done),  d);
      chk({tag, ".wrap"},  int'(bus.wrap),  w);
   endtask

   initial begin
      vec_t tbl[21];
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2, 5,   2, 1, 0, 0};
      tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2, 5,   3, 1, 0, 0};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2, 5,   4, 1, 0, 0};
      tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2, 5,   5, 1, 0, 0};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2, 5,   5, 0, 1, 0};
      tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2, 5,   5, 0, 0, 0};
      tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 14,  1, 1, 0, 0};
      tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 9, 9,   0, 1, 0, 0};
      tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 14, 15, 1, 0, 1};
      tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 14, 14, 1, 0, 0};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 14, 14, 0, 1, 0};
      tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 14, 14, 0, 0, 0};
      tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3, 5,   3, 1, 0, 0};
      tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3, 5,   4, 1, 0, 0};
      tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3, 5,   5, 1, 0, 0};
      tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3, 5,   3, 1, 1, 0};
      tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3, 5,   4, 1, 0, 0};
      tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3, 5,   5, 1, 0, 0};
      tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3, 5,   3, 1, 1, 0};
      tbl[19] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3, 5,   3, 0, 0, 0};
      tbl[20] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3, 5,   3, 0, 0, 0};

      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      reset = 1'b0;
      edge_only();
      edge_only();
      expect_now("reset", 0, 0, 0, 0);
      reset = 1'b1;

`ifndef COUNTER_SEQ_PRESCALER_EN
      // Basic runs, direction wrap, ignored start, auto-reload and abort.
      for (int i = 0; i < 21; i++) begin
         drive(tbl[i].st, tbl[i].ab, tbl[i].pa, tbl[i].up, tbl[i].rl, tbl[i].ld, tbl[i].tm);
         edge_only();
         expect_now($sformatf("vec%0d", i), tbl[i].c, tbl[i].b, tbl[i].d, tbl[i].w);
      end

      // Pause at count 4 for three cycles.
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 9);
      edge_only();
      expect_now("pause.load", 0, 1, 0, 0);
      bus.start = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         edge_only();
         expect_now($sformatf("pause.pre%0d", k), k, 1, 0, 0);
      end
      bus.pause = 1'b1;
      for (int k = 0; k < 3; k++) begin
         edge_only();
         expect_now($sformatf("pause.hold%0d", k), 4, 1, 0, 0);
      end
      bus.pause = 1'b0;
      edge_only();
      expect_now("pause.resume", 4, 1, 0, 0);
      for (int k = 5; k <= 9; k++) begin
         edge_only();
         expect_now($sformatf("pause.post%0d", k), k, 1, 0, 0);
      end
      edge_only();
      expect_now("pause.done", 9, 0, 1, 0);
      edge_only();
      expect_now("pause.idle", 9, 0, 0, 0);

      // Reset in the middle of a run, after an ignored start.
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 15);
      edge_only();
      bus.start = 1'b0;
      for (int k = 1; k <= 6; k++) edge_only();
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3, 3);
      edge_only();
      expect_now("midreset.pre", 7, 1, 0, 0);
      bus.start = 1'b0;
      reset = 1'b0;
      edge_only();
      expect_now("midreset.post", 0, 0, 0, 0);
      reset = 1'b1;
`else
      // Prescaled run: one step every P+1 clocks.
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 2);
      edge_only();
      expect_now("presc.load", 0, 1, 0, 0);
      bus.start = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         edge_only();
         expect_now($sformatf("presc.k%0d", k), (k / 4 > 2) ? 2 : k / 4,
                    (k == 12) ? 0 : 1, (k == 12) ? 1 : 0, 0);
      end
      edge_only();
      expect_now("presc.idle", 2, 0, 0, 0);
`endif

      // Randomized traffic against the reference model.
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      reset = 1'b0;
      step_check("rnd.reset");
      reset = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         reset = ($urandom_range(0, 199) != 0);
         drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 39) == 0),
               ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), int'($urandom_range(0, MAXV)),
               int'($urandom_range(0, MAXV)));
         step_check($sformatf("rnd%0d", n));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
